fft_stage_scheduler: RTL and testbench

- Sequencer for the shared radix-2 butterfly datapath of the 32-point FFT.
- On `start`, it issues all 16 butterflies of each of the 5 DIT stages.
- For each butterfly it produces operand addresses, twiddle index and ping-pong bank selects.
- It inserts pipeline drain gaps between stages, then reports completion with a one-cycle `done`.
- Sits between the top-level control unit and the butterfly/memory datapath.

---
 rtl/fft_pkg.sv | 18 +
 rtl/fft_stage_scheduler_if.sv | 40 ++++
 rtl/fft_bf_addr_gen.sv | 35 +++
 rtl/fft_stage_scheduler.sv | 146 ++++++++++++++
 tb/tb_fft_stage_scheduler.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared constants and types for the 32-point FFT stage scheduler.
package fft_pkg;

    localparam int FFT_N_LOG2 = 5;
    localparam int FFT_BF_LAT = 3;

    localparam int ADDR_W  = FFT_N_LOG2;
    localparam int TW_W    = FFT_N_LOG2 - 1;
    localparam int STAGE_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } sched_state_t;

endpackage

// File: rtl/fft_stage_scheduler_if.sv
// Control/issue bundle between the FFT control unit, the scheduler and the butterfly datapath.
// The hold input exists only when FFT_SCHED_HOLD_EN is defined.
interface fft_stage_scheduler_if
    import fft_pkg::*;
#(
    parameter int N_LOG2 = FFT_N_LOG2
);

    logic                start;
    logic                busy;
    logic                done;
    logic                bf_valid;
    logic [N_LOG2-1:0]   addr_a;
    logic [N_LOG2-1:0]   addr_b;
    logic [N_LOG2-2:0]   tw_idx;
    logic [STAGE_W-1:0]  stage;
    logic                rd_bank;
    logic                wr_bank;
`ifdef FFT_SCHED_HOLD_EN
    logic                hold;
`endif

    // master is the scheduler itself; slave is the control unit / datapath side
    modport master (
`ifdef FFT_SCHED_HOLD_EN
        input  hold,
`endif
        input  start,
        output busy, done, bf_valid, addr_a, addr_b, tw_idx, stage, rd_bank, wr_bank
    );

    modport slave (
`ifdef FFT_SCHED_HOLD_EN
        output hold,
`endif
        output start,
        input  busy, done, bf_valid, addr_a, addr_b, tw_idx, stage, rd_bank, wr_bank
    );

endinterface

// File: rtl/fft_bf_addr_gen.sv
// Radix-2 DIT butterfly address generator: (stage, k) -> operand addresses and twiddle index.
module fft_bf_addr_gen
    import fft_pkg::*;
#(
    parameter int N_LOG2 = FFT_N_LOG2
) (
    input  logic [STAGE_W-1:0] stage,
    input  logic [N_LOG2-2:0]  k,
    output logic [N_LOG2-1:0]  addr_a,
    output logic [N_LOG2-1:0]  addr_b,
    output logic [N_LOG2-2:0]  tw_idx
);

    localparam int A_W = N_LOG2;
    localparam int K_W = N_LOG2 - 1;

    logic [A_W-1:0]     k_ext;
    logic [A_W-1:0]     span;
    logic [A_W-1:0]     grp;
    logic [A_W-1:0]     pos;
    logic [STAGE_W-1:0] tw_sh;

    // pos < span always holds, so narrowing pos to the twiddle width loses nothing
    always_comb begin
        k_ext  = A_W'(k);
        span   = A_W'(1) << stage;
        grp    = k_ext >> stage;
        pos    = k_ext & (span - A_W'(1));
        addr_a = ((grp << stage) << 1) + pos;
        addr_b = addr_a + span;
        tw_sh  = STAGE_W'(N_LOG2 - 1) - stage;
        tw_idx = K_W'(pos) << tw_sh;
    end

endmodule

// File: rtl/fft_stage_scheduler.sv
// Issue sequencer for the shared radix-2 butterfly: 5 DIT stages x 16 butterflies with drain gaps.
// Define FFT_SCHED_HOLD_EN to add a hold input that pauses issue while in RUN.
module fft_stage_scheduler
    import fft_pkg::*;
#(
    parameter int N_LOG2 = FFT_N_LOG2,
    parameter int BF_LAT = FFT_BF_LAT
) (
    input  logic                  clk_100,
    input  logic                  rst_n,
    fft_stage_scheduler_if.master bus
);

    localparam int A_W = N_LOG2;
    localparam int K_W = N_LOG2 - 1;
    localparam int D_W = $clog2(BF_LAT + 1);

    localparam logic [K_W-1:0]     K_LAST = '1;
    localparam logic [STAGE_W-1:0] S_LAST = STAGE_W'(N_LOG2 - 1);
    localparam logic [D_W-1:0]     D_LAST = D_W'(BF_LAT);

    sched_state_t        state;
    logic [K_W-1:0]      k_r;
    logic [STAGE_W-1:0]  stage_r;
    logic [D_W-1:0]      drain_cnt;
    logic                busy_r;
    logic                done_r;
    logic                bf_valid_r;
    logic [A_W-1:0]      addr_a_r;
    logic [A_W-1:0]      addr_b_r;
    logic [K_W-1:0]      tw_r;
    logic                rd_bank_r;
    logic                wr_bank_r;

    logic                hold_i;
    logic                issue;
    logic [STAGE_W-1:0]  gen_stage;
    logic [A_W-1:0]      gen_a;
    logic [A_W-1:0]      gen_b;
    logic [K_W-1:0]      gen_tw;

`ifdef FFT_SCHED_HOLD_EN
    assign hold_i = bus.hold;
`else
    assign hold_i = 1'b0;
`endif

    // k_r always names the butterfly issued at the next edge; in DRAIN that is k=0 of the next stage
    always_comb begin
        gen_stage = stage_r;
        issue     = 1'b0;
        case (state)
            IDLE:    issue = bus.start;
            RUN:     issue = !hold_i;
            DRAIN: begin
                issue = (drain_cnt == D_LAST) && (stage_r != S_LAST);
                if (stage_r != S_LAST) gen_stage = stage_r + 1'b1;
            end
            default: issue = 1'b0;
        endcase
    end

    fft_bf_addr_gen #(.N_LOG2(N_LOG2)) u_addr_gen (
        .stage  (gen_stage),
        .k      (k_r),
        .addr_a (gen_a),
        .addr_b (gen_b),
        .tw_idx (gen_tw)
    );

    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            k_r        <= '0;
            stage_r    <= '0;
            drain_cnt  <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            bf_valid_r <= 1'b0;
            addr_a_r   <= '0;
            addr_b_r   <= '0;
            tw_r       <= '0;
            rd_bank_r  <= 1'b0;
            wr_bank_r  <= 1'b1;
        end else begin
            bf_valid_r <= issue;
            done_r     <= 1'b0;
            if (issue) begin
                addr_a_r <= gen_a;
                addr_b_r <= gen_b;
                tw_r     <= gen_tw;
            end
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= RUN;
                        busy_r <= 1'b1;
                        k_r    <= K_W'(1);
                    end
                end
                RUN: begin
                    if (!hold_i) begin
                        k_r <= k_r + 1'b1;
                        if (k_r == K_LAST) begin
                            state     <= DRAIN;
                            drain_cnt <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt != D_LAST) begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end else if (stage_r == S_LAST) begin
                        state  <= DONE;
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                    end else begin
                        state     <= RUN;
                        stage_r   <= stage_r + 1'b1;
                        k_r       <= K_W'(1);
                        rd_bank_r <= ~stage_r[0];
                        wr_bank_r <= stage_r[0];
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    stage_r   <= '0;
                    rd_bank_r <= 1'b0;
                    wr_bank_r <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.bf_valid = bf_valid_r;
    assign bus.addr_a   = addr_a_r;
    assign bus.addr_b   = addr_b_r;
    assign bus.tw_idx   = tw_r;
    assign bus.stage    = stage_r;
    assign bus.rd_bank  = rd_bank_r;
    assign bus.wr_bank  = wr_bank_r;

endmodule

// File: tb/tb_fft_stage_scheduler.sv
// Directed bench for fft_stage_scheduler: issue table, latency, ignored starts, reset abort, hold.
module tb_fft_stage_scheduler;
    import fft_pkg::*;

    typedef struct {
        int idx;
        int cyc;
        int stg;
        int a;
        int b;
        int tw;
        int rd;
        int wr;
    } vec_t;

    logic clk_100 = 1'b0;
    logic rst_n   = 1'b0;

    int checks = 0;
    int errors = 0;

    int issue_cnt;
    int done_cnt;
    int done_cyc;
    int busy_at_done;
    int busy_at_1;
    int iss_cyc [80];
    int iss_stg [80];
    int iss_a   [80];
    int iss_b   [80];
    int iss_tw  [80];
    int iss_rd  [80];
    int iss_wr  [80];

    vec_t vecs [9];

    fft_stage_scheduler_if #(.N_LOG2(5)) bus ();

    fft_stage_scheduler #(.N_LOG2(5), .BF_LAT(3)) dut (
        .clk_100 (clk_100),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 clk_100 = ~clk_100;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic h);
        bus.start = s;
`ifdef FFT_SCHED_HOLD_EN
        bus.hold = h;
`else
        if (h) $display("[TB] hold request ignored in this build");
`endif
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " busy"},     int'(bus.busy),     0);
        checkOutput({tag, " done"},     int'(bus.done),     0);
        checkOutput({tag, " bf_valid"}, int'(bus.bf_valid), 0);
        checkOutput({tag, " addr_a"},   int'(bus.addr_a),   0);
        checkOutput({tag, " addr_b"},   int'(bus.addr_b),   0);
        checkOutput({tag, " tw_idx"},   int'(bus.tw_idx),   0);
        checkOutput({tag, " stage"},    int'(bus.stage),    0);
        checkOutput({tag, " rd_bank"},  int'(bus.rd_bank),  0);
        checkOutput({tag, " wr_bank"},  int'(bus.wr_bank),  1);
    endtask

    // Called at a negedge with the DUT idle: raises start for cycle 0, then observes cycles 1..n_cycles
    task automatic runTransform(input int pulse_a, input int pulse_b,
                                input int hold_lo, input int hold_hi, input int n_cycles);
        issue_cnt    = 0;
        done_cnt     = 0;
        done_cyc     = -1;
        busy_at_done = -1;
        busy_at_1    = -1;
        applyStimulus(1'b1, 1'b0);
        for (int n = 1; n <= n_cycles; n++) begin
            @(negedge clk_100);
            applyStimulus(n == pulse_a || n == pulse_b, n >= hold_lo && n <= hold_hi);
            if (n == 1) busy_at_1 = int'(bus.busy);
            if (bus.bf_valid) begin
                if (issue_cnt < 80) begin
                    iss_cyc[issue_cnt] = n;
                    iss_stg[issue_cnt] = int'(bus.stage);
                    iss_a[issue_cnt]   = int'(bus.addr_a);
                    iss_b[issue_cnt]   = int'(bus.addr_b);
                    iss_tw[issue_cnt]  = int'(bus.tw_idx);
                    iss_rd[issue_cnt]  = int'(bus.rd_bank);
                    iss_wr[issue_cnt]  = int'(bus.wr_bank);
                end
                issue_cnt++;
            end
            if (bus.done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc     = n;
                    busy_at_done = int'(bus.busy);
                end
            end
        end
        applyStimulus(1'b0, 1'b0);
    endtask

    initial begin
        int idle_valid;
        int first_again;

        // idx = issue number, cyc = 1 + 19*stage + k
        vecs[0] = '{idx:  0, cyc:  1, stg: 0, a:  0, b:  1, tw:  0, rd: 0, wr: 1};
        vecs[1] = '{idx:  1, cyc:  2, stg: 0, a:  2, b:  3, tw:  0, rd: 0, wr: 1};
        vecs[2] = '{idx:  2, cyc:  3, stg: 0, a:  4, b:  5, tw:  0, rd: 0, wr: 1};
        vecs[3] = '{idx: 15, cyc: 16, stg: 0, a: 30, b: 31, tw:  0, rd: 0, wr: 1};
        vecs[4] = '{idx: 16, cyc: 20, stg: 1, a:  0, b:  2, tw:  0, rd: 1, wr: 0};
        vecs[5] = '{idx: 19, cyc: 23, stg: 1, a:  5, b:  7, tw:  8, rd: 1, wr: 0};
        vecs[6] = '{idx: 37, cyc: 44, stg: 2, a:  9, b: 13, tw:  4, rd: 0, wr: 1};
        vecs[7] = '{idx: 58, cyc: 68, stg: 3, a: 18, b: 26, tw:  4, rd: 1, wr: 0};
        vecs[8] = '{idx: 79, cyc: 92, stg: 4, a: 15, b: 31, tw: 15, rd: 0, wr: 1};

        applyStimulus(1'b0, 1'b0);
        repeat (3) @(negedge clk_100);
        checkResetValues("reset");
        rst_n = 1'b1;

        idle_valid = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk_100);
            if (bus.bf_valid || bus.busy) idle_valid++;
        end
        checkOutput("idle no activity", idle_valid, 0);

        $display("[TB] nominal transform");
        runTransform(-1, -1, -1, -1, 110);
        checkOutput("nominal issues", issue_cnt, 80);
        checkOutput("nominal done cycle", done_cyc, 96);
        checkOutput("nominal done count", done_cnt, 1);
        checkOutput("nominal busy at done", busy_at_done, 0);
        checkOutput("nominal busy at 1", busy_at_1, 1);
        for (int i = 0; i < 9; i++) begin
            int j;
            j = vecs[i].idx;
            checkOutput($sformatf("vec%0d cycle", i),   iss_cyc[j], vecs[i].cyc);
            checkOutput($sformatf("vec%0d stage", i),   iss_stg[j], vecs[i].stg);
            checkOutput($sformatf("vec%0d addr_a", i),  iss_a[j],   vecs[i].a);
            checkOutput($sformatf("vec%0d addr_b", i),  iss_b[j],   vecs[i].b);
            checkOutput($sformatf("vec%0d tw_idx", i),  iss_tw[j],  vecs[i].tw);
            checkOutput($sformatf("vec%0d rd_bank", i), iss_rd[j],  vecs[i].rd);
            checkOutput($sformatf("vec%0d wr_bank", i), iss_wr[j],  vecs[i].wr);
        end

        $display("[TB] start pulses while busy");
        runTransform(10, 50, -1, -1, 110);
        checkOutput("busy-start issues", issue_cnt, 80);
        checkOutput("busy-start done cycle", done_cyc, 96);
        checkOutput("busy-start done count", done_cnt, 1);

        $display("[TB] reset mid-operation");
        applyStimulus(1'b1, 1'b0);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk_100);
            applyStimulus(1'b0, 1'b0);
        end
        checkOutput("pre-abort bf_valid", int'(bus.bf_valid), 1);
        checkOutput("pre-abort stage", int'(bus.stage), 2);
        checkOutput("pre-abort addr_a", int'(bus.addr_a), 1);
        checkOutput("pre-abort addr_b", int'(bus.addr_b), 5);
        checkOutput("pre-abort tw_idx", int'(bus.tw_idx), 4);
        rst_n = 1'b0;
        #1;
        checkResetValues("abort");
        done_cnt = 0;
        repeat (3) begin
            @(negedge clk_100);
            if (bus.done) done_cnt++;
        end
        checkOutput("abort no done", done_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk_100);
        runTransform(-1, -1, -1, -1, 110);
        checkOutput("post-abort issues", issue_cnt, 80);
        checkOutput("post-abort done cycle", done_cyc, 96);
        checkOutput("post-abort first addr_b", iss_b[0], 1);

        $display("[TB] start held high");
        applyStimulus(1'b1, 1'b0);
        done_cyc    = -1;
        first_again = -1;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk_100);
            if (bus.done && done_cyc < 0) done_cyc = n;
            if (n > 96 && bus.bf_valid && first_again < 0) first_again = n;
        end
        checkOutput("held-start done cycle", done_cyc, 96);
        checkOutput("held-start restart cycle", first_again, 98);
        applyStimulus(1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk_100);
        rst_n = 1'b1;
        @(negedge clk_100);

`ifdef FFT_SCHED_HOLD_EN
        $display("[TB] hold during stage 0");
        runTransform(-1, -1, 5, 9, 115);
        checkOutput("hold issues", issue_cnt, 80);
        checkOutput("hold done cycle", done_cyc, 101);
        checkOutput("hold last pre-pause addr_a", iss_a[4], 8);
        checkOutput("hold resume cycle", iss_cyc[5], 11);
        checkOutput("hold resume addr_a", iss_a[5], 10);
        checkOutput("hold resume addr_b", iss_b[5], 11);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
